// File: rtl/eth_phy_10g_pkg.sv
// Shared definitions for the 10G PHY receive path: sync-header codes,
// block-lock FSM encoding and small helper functions.
package eth_phy_10g_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SLIP   = 2'd1,
    ST_LOCKED = 2'd2
  } rx_lock_state_e;

  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eth_phy_10g_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle
// increment.
module eth_phy_10g_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             rx_clk,
  input  logic             rx_rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the values that existed before the clock edge.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/eth_phy_10g_rx_hdr_lock_mon.sv
// 64b/66b sync-header block-lock monitor: hunts for lock with bitslip pulses,
// drops lock on too many header errors per window, keeps header statistics.
module eth_phy_10g_rx_hdr_lock_mon
  import eth_phy_10g_pkg::*;
#(
  parameter int HDR_WIDTH           = 2,
  parameter int LOCK_COUNT          = 64,
  parameter int SH_WINDOW           = 64,
  parameter int INVALID_MAX         = 16,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
  input  logic                 serdes_rx_hdr_valid,
  input  logic                 stat_clear,
  output logic                 serdes_rx_bitslip,
  output logic                 rx_block_lock,
  output logic [CNT_WIDTH-1:0] stat_valid_count,
  output logic [CNT_WIDTH-1:0] stat_invalid_count,
  output logic [CNT_WIDTH-1:0] stat_lock_count
);

  localparam int CW         = $clog2(max_int(LOCK_COUNT, SH_WINDOW) + 1);
  localparam int SLIP_TOTAL = BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES;
  localparam int SW         = $clog2(SLIP_TOTAL + 1);

  localparam logic [CW-1:0] RUN_LAST  = CW'(LOCK_COUNT - 1);
  localparam logic [CW-1:0] WIN_LAST  = CW'(SH_WINDOW - 1);
  localparam logic [CW-1:0] ERR_LAST  = CW'(INVALID_MAX - 1);
  localparam logic [SW-1:0] SLIP_LAST = SW'(SLIP_TOTAL - 1);
  localparam logic [SW-1:0] SLIP_HIGH = SW'(BITSLIP_HIGH_CYCLES);

  rx_lock_state_e state;
  logic [CW-1:0]  run_cnt;
  logic [CW-1:0]  beat_cnt;
  logic [CW-1:0]  err_cnt;
  logic [SW-1:0]  slip_cnt;

  logic          hdr_ok;
  logic          beat;
  logic          valid_inc;
  logic          invalid_inc;
  logic          lock_inc;
  logic [SW-1:0] slip_nxt;

  // NOTE: every signal gets a default at the top of always_comb, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    hdr_ok      = hdr_is_valid(serdes_rx_hdr);
    beat        = serdes_rx_hdr_valid && (state != ST_SLIP);
    valid_inc   = beat && hdr_ok;
    invalid_inc = beat && !hdr_ok;
    lock_inc    = (state == ST_HUNT) && valid_inc && (run_cnt == RUN_LAST);
    slip_nxt    = slip_cnt + 1'b1;
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state             <= ST_HUNT;
      run_cnt           <= '0;
      beat_cnt          <= '0;
      err_cnt           <= '0;
      slip_cnt          <= '0;
      serdes_rx_bitslip <= 1'b0;
      rx_block_lock     <= 1'b0;
    end else begin
      case (state)
        ST_HUNT: begin
          if (valid_inc) begin
            if (run_cnt == RUN_LAST) begin
              state         <= ST_LOCKED;
              rx_block_lock <= 1'b1;
              run_cnt       <= '0;
              beat_cnt      <= '0;
              err_cnt       <= '0;
            end else begin
              run_cnt <= run_cnt + 1'b1;
            end
          end else if (invalid_inc) begin
            state             <= ST_SLIP;
            run_cnt           <= '0;
            slip_cnt          <= '0;
            serdes_rx_bitslip <= 1'b1;
          end
        end
        // Slip timer is free-running: header beats are ignored while settling.
        ST_SLIP: begin
          if (slip_cnt == SLIP_LAST) begin
            state             <= ST_HUNT;
            slip_cnt          <= '0;
            serdes_rx_bitslip <= 1'b0;
          end else begin
            slip_cnt          <= slip_nxt;
            serdes_rx_bitslip <= (slip_nxt < SLIP_HIGH);
          end
        end
        ST_LOCKED: begin
          if (beat) begin
            // Loss of lock takes priority over the window rollover.
            if (invalid_inc && (err_cnt == ERR_LAST)) begin
              state             <= ST_SLIP;
              rx_block_lock     <= 1'b0;
              slip_cnt          <= '0;
              serdes_rx_bitslip <= 1'b1;
            end else if (beat_cnt == WIN_LAST) begin
              beat_cnt <= '0;
              err_cnt  <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              err_cnt  <= err_cnt + CW'(invalid_inc);
            end
          end
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

  eth_phy_10g_sat_cnt #(.WIDTH(CNT_WIDTH)) u_valid_cnt (
    .rx_clk (rx_clk),
    .rx_rst (rx_rst),
    .inc    (valid_inc),
    .clr    (stat_clear),
    .count  (stat_valid_count)
  );

  eth_phy_10g_sat_cnt #(.WIDTH(CNT_WIDTH)) u_invalid_cnt (
    .rx_clk (rx_clk),
    .rx_rst (rx_rst),
    .inc    (invalid_inc),
    .clr    (stat_clear),
    .count  (stat_invalid_count)
  );

  eth_phy_10g_sat_cnt #(.WIDTH(CNT_WIDTH)) u_lock_cnt (
    .rx_clk (rx_clk),
    .rx_rst (rx_rst),
    .inc    (lock_inc),
    .clr    (stat_clear),
    .count  (stat_lock_count)
  );

endmodule
